// File: rtl/dvp_rx_pkg.sv
// Shared DVP RX definitions: AXI widths, BRESP encoding and write-scheduler state encoding.
package dvp_rx_pkg;

   localparam int unsigned AXI_DATA_W = 256;
   localparam int unsigned AXI_ADDR_W = 32;
   localparam int unsigned AXI_ID_W   = 5;
   localparam int unsigned AXI_LEN_W  = 8;
   localparam int unsigned AXI_RESP_W = 2;

   typedef enum logic [AXI_RESP_W-1:0] {
      BRESP_OKAY   = 2'b00,
      BRESP_EXOKAY = 2'b01,
      BRESP_SLVERR = 2'b10,
      BRESP_DECERR = 2'b11
   } bresp_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      RUN      = 2'd2,
      DRAIN    = 2'd3
   } sched_state_t;

   // Bits needed to hold the values 0..max_val (never less than one).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val > 1) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/axi_wr_outst_cnt.sv
// Saturating up/down count of AXI requests still waiting for a response, flagged full at MAX_OUTST.
module axi_wr_outst_cnt
   import dvp_rx_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 4,
   parameter int unsigned CNT_W     = cnt_width(MAX_OUTST)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_full,
   output logic             o_empty
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_full;
   logic             w_empty;

   assign w_full  = (r_cnt == CNT_W'(MAX_OUTST));
   assign w_empty = (r_cnt == '0);

   // Simultaneous request and response cancel out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && !i_dec && !w_full) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_dec && !i_inc && !w_empty) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_cnt   = r_cnt;
   assign o_full  = w_full;
   assign o_empty = w_empty;

endmodule

// File: rtl/dvp_frame_wr_sched.sv
// Schedules AXI4 write bursts carrying DVP pixel beats into a ping-pong frame buffer.
module dvp_frame_wr_sched
   import dvp_rx_pkg::*;
#(
   parameter int unsigned TX_DATA_W       = AXI_DATA_W,
   parameter int unsigned ADDR_W          = AXI_ADDR_W,
   parameter int unsigned MST_ID_W        = AXI_ID_W,
   parameter int unsigned BURST_LEN       = 16,
   parameter int unsigned BEATS_PER_FRAME = 2400,
   parameter int unsigned MAX_OUTST       = 4,
   parameter int unsigned AXI_ID          = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cfg_start_i,
   input  logic                  cfg_stop_i,
   input  logic [ADDR_W-1:0]     cfg_base0_i,
   input  logic [ADDR_W-1:0]     cfg_base1_i,
   input  logic [TX_DATA_W-1:0]  pxl_data_i,
   input  logic                  pxl_sof_i,
   input  logic                  pxl_valid_i,
   output logic                  pxl_ready_o,
   output logic [MST_ID_W-1:0]   s_awid_o,
   output logic [ADDR_W-1:0]     s_awaddr_o,
   output logic [AXI_LEN_W-1:0]  s_awlen_o,
   output logic                  s_awvalid_o,
   input  logic                  s_awready_i,
   output logic [TX_DATA_W-1:0]  s_wdata_o,
   output logic                  s_wlast_o,
   output logic                  s_wvalid_o,
   input  logic                  s_wready_i,
   input  logic [MST_ID_W-1:0]   s_bid_i,
   input  logic [AXI_RESP_W-1:0] s_bresp_i,
   input  logic                  s_bvalid_i,
   output logic                  s_bready_o,
   output logic                  busy_o,
   output logic                  cur_buf_o,
   output logic                  frame_done_o,
   output logic                  err_o
);

   localparam int unsigned TOTAL_BURSTS = BEATS_PER_FRAME / BURST_LEN;
   localparam int unsigned BIDX_W       = cnt_width(TOTAL_BURSTS);
   localparam int unsigned BEAT_W       = cnt_width(BURST_LEN - 1);
   localparam int unsigned OUT_W        = cnt_width(MAX_OUTST);
   localparam int unsigned BURST_BYTES  = BURST_LEN * TX_DATA_W / 8;

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic                r_cur_buf;
   logic                r_stop_pend;
   logic                r_err;
   logic                r_frame_done;
   logic                r_awvalid;
   logic [ADDR_W-1:0]   r_base;
   logic [ADDR_W-1:0]   r_awaddr;
   logic [BIDX_W-1:0]   r_aw_idx;
   logic [BIDX_W-1:0]   r_w_burst_idx;
   logic [BEAT_W-1:0]   r_beat_cnt;

   logic                w_aw_hs;
   logic                w_w_hs;
   logic                w_b_hs;
   logic                w_w_en;
   logic                w_sof_hit;
   logic                w_aw_issue;
   logic                w_frame_end;
   logic                w_start;
   logic [OUT_W-1:0]    w_outst;
   logic                w_outst_full;
   logic                w_outst_empty;
   logic                w_unused_bid;

   assign w_unused_bid = ^{s_bid_i, w_outst};

   // W may only run inside bursts whose AW has already been accepted.
   assign w_w_en      = (r_state == RUN) && (r_aw_idx > r_w_burst_idx);
   assign w_aw_hs     = r_awvalid & s_awready_i;
   assign w_w_hs      = s_wvalid_o & s_wready_i;
   assign w_b_hs      = s_bvalid_i & s_bready_o;
   assign w_sof_hit   = (r_state == WAIT_SOF) & pxl_valid_i & pxl_sof_i;
   assign w_aw_issue  = (r_state == RUN) & ~r_awvalid & ~w_outst_full
                        & (r_aw_idx < BIDX_W'(TOTAL_BURSTS));
   assign w_frame_end = (r_state == DRAIN) & w_outst_empty;
   assign w_start     = (r_state == IDLE) & cfg_start_i & ~cfg_stop_i;

   axi_wr_outst_cnt #(
      .MAX_OUTST (MAX_OUTST),
      .CNT_W     (OUT_W)
   ) u_outst (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_aw_hs),
      .i_dec   (w_b_hs),
      .o_cnt   (w_outst),
      .o_full  (w_outst_full),
      .o_empty (w_outst_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_start) w_state_nxt = WAIT_SOF;
         WAIT_SOF: begin
            if (cfg_stop_i)     w_state_nxt = IDLE;
            else if (w_sof_hit) w_state_nxt = RUN;
         end
         RUN: begin
            if ((r_aw_idx == BIDX_W'(TOTAL_BURSTS)) && (r_w_burst_idx == BIDX_W'(TOTAL_BURSTS)))
               w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_outst_empty) w_state_nxt = (r_stop_pend || cfg_stop_i) ? IDLE : WAIT_SOF;
         end
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cur_buf     <= 1'b0;
         r_stop_pend   <= 1'b0;
         r_err         <= 1'b0;
         r_frame_done  <= 1'b0;
         r_awvalid     <= 1'b0;
         r_base        <= '0;
         r_awaddr      <= '0;
         r_aw_idx      <= '0;
         r_w_burst_idx <= '0;
         r_beat_cnt    <= '0;
      end else begin
         r_frame_done <= w_frame_end;
         if (w_frame_end) r_cur_buf <= ~r_cur_buf;

         if (w_start)                                            r_err <= 1'b0;
         else if (w_b_hs && (bresp_t'(s_bresp_i) != BRESP_OKAY)) r_err <= 1'b1;

         if (w_state_nxt == IDLE)                                r_stop_pend <= 1'b0;
         else if (cfg_stop_i && (r_state inside {RUN, DRAIN}))   r_stop_pend <= 1'b1;

         if (w_sof_hit) r_base <= r_cur_buf ? cfg_base1_i : cfg_base0_i;

         // Per-frame counters restart while no frame is in flight.
         if (r_state inside {IDLE, WAIT_SOF}) begin
            r_aw_idx      <= '0;
            r_w_burst_idx <= '0;
            r_beat_cnt    <= '0;
         end else begin
            if (w_aw_hs) r_aw_idx <= r_aw_idx + BIDX_W'(1);
            if (w_w_hs) begin
               if (r_beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                  r_beat_cnt    <= '0;
                  r_w_burst_idx <= r_w_burst_idx + BIDX_W'(1);
               end else begin
                  r_beat_cnt    <= r_beat_cnt + BEAT_W'(1);
               end
            end
         end

         // Address is captured when AWVALID rises and held until accepted.
         if (w_aw_hs) begin
            r_awvalid <= 1'b0;
         end else if (w_aw_issue) begin
            r_awvalid <= 1'b1;
            r_awaddr  <= r_base + ADDR_W'(r_aw_idx) * ADDR_W'(BURST_BYTES);
         end
      end
   end

   assign s_awid_o     = MST_ID_W'(AXI_ID);
   assign s_awlen_o    = AXI_LEN_W'(BURST_LEN - 1);
   assign s_awaddr_o   = r_awaddr;
   assign s_awvalid_o  = r_awvalid;
   assign s_wdata_o    = pxl_data_i;
   assign s_wvalid_o   = pxl_valid_i & w_w_en;
   assign s_wlast_o    = w_w_en & (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
   assign s_bready_o   = ~w_outst_empty;
   // Pre-SOF beats are discarded; the SOF beat itself is held for RUN.
   assign pxl_ready_o  = (r_state == WAIT_SOF) ? ~(pxl_valid_i & pxl_sof_i)
                                               : (w_w_en & s_wready_i);
   assign busy_o       = (r_state == RUN) || (r_state == DRAIN);
   assign cur_buf_o    = r_cur_buf;
   assign frame_done_o = r_frame_done;
   assign err_o        = r_err;

endmodule
